apb_wide_reg_bank: RTL and testbench



---
 rtl/apb_wide_reg_bank.sv | 239 +++++++++++++++++++++++
 tb/tb_apb_wide_reg_bank.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_wide_reg_bank.sv
// APB slave exposing wide external registers through 32-bit slices and one memory window.
// Writes are staged in a shared shadow and committed atomically on the final slice.
// Reads snapshot the whole register on slice 0 so the upper slices stay coherent.
module apb_wide_reg_bank #(
    parameter int unsigned NUM_EXT    = 4,
    parameter int unsigned DATA_W     = 37,
    parameter int unsigned MEM_AW     = 6,
    parameter int unsigned MEM_DW     = 32,
    parameter int unsigned MEM_RD_LAT = 2,
    parameter int unsigned ADDR_W     = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [ADDR_W-1:0]         paddr,
    input  logic [31:0]               pwdata,
    output logic [31:0]               prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic [NUM_EXT-1:0]        ext_write,
    output logic [DATA_W-1:0]         ext_wdata,
    input  logic [NUM_EXT*DATA_W-1:0] ext_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [MEM_AW-1:0]         mem_addr,
    output logic [MEM_DW-1:0]         mem_wdata,
    input  logic [MEM_DW-1:0]         mem_rdata
);

    localparam int unsigned WPR       = (DATA_W + 31) / 32;
    localparam int unsigned SLG       = $clog2(WPR);
    localparam int unsigned STRIDE    = 1 << SLG;
    localparam int unsigned PADW      = WPR * 32;
    localparam int unsigned SLW       = (SLG > 0) ? SLG : 1;
    localparam int unsigned IDXW      = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
    localparam int unsigned MEM_BASE  = 1 << (ADDR_W - 3);
    localparam int unsigned MEM_WORDS = 1 << MEM_AW;
    localparam int unsigned CNTW      = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, MEM_WAIT, RESP} state_t;

    state_t              state_q;
    logic                acc_reg_q, acc_mem_q, acc_wr_q;
    logic [IDXW-1:0]     acc_idx_q;
    logic [SLW-1:0]      acc_slice_q;
    logic [31:0]         wdata_q;
    logic [CNTW-1:0]     cnt_q;
    logic [PADW-1:0]     wsh_q;
    logic [IDXW-1:0]     wown_q;
    logic [DATA_W-1:0]   rsh_q;
    logic [IDXW-1:0]     rown_q;
    logic                rvalid_q;
    logic [31:0]         prdata_q;
    logic                pready_q, pslverr_q;
    logic [NUM_EXT-1:0]  ext_write_q;
    logic [DATA_W-1:0]   ext_wdata_q;
    logic                mem_en_q, mem_we_q;
    logic [MEM_AW-1:0]   mem_addr_q;
    logic [MEM_DW-1:0]   mem_wdata_q;

    logic [31:0]         word_c;
    logic                dec_reg_c, dec_mem_c;
    logic [IDXW-1:0]     dec_idx_c;
    logic [SLW-1:0]      dec_slice_c;
    logic [DATA_W-1:0]   live_c;
    logic [PADW-1:0]     live_pad_c, snap_pad_c, wcomp_c;
    logic                use_snap_c;
    logic [31:0]         rd_word_c;
    logic                unused_c;

    assign word_c     = 32'(paddr[ADDR_W-1:2]);
    assign live_pad_c = PADW'(live_c);
    assign snap_pad_c = PADW'(rsh_q);
    assign use_snap_c = rvalid_q && (rown_q == acc_idx_q);
    assign unused_c   = ^{paddr[1:0], wcomp_c};

    // Word-address decode of the setup-phase address.
    always_comb begin
        dec_reg_c   = 1'b0;
        dec_mem_c   = 1'b0;
        dec_idx_c   = '0;
        dec_slice_c = '0;
        if (word_c >= MEM_BASE && word_c < MEM_BASE + MEM_WORDS) begin
            dec_mem_c = 1'b1;
        end else if ((word_c >> SLG) < NUM_EXT && (word_c & (STRIDE - 1)) < WPR) begin
            dec_reg_c   = 1'b1;
            dec_idx_c   = IDXW'(word_c >> SLG);
            dec_slice_c = SLW'(word_c & (STRIDE - 1));
        end
    end

    // Live value of the register being accessed.
    always_comb begin
        live_c = '0;
        for (int unsigned i = 0; i < NUM_EXT; i++) begin
            if (acc_idx_q == IDXW'(i)) live_c = ext_rdata[i*DATA_W +: DATA_W];
        end
    end

    // Read slice: slice 0 is live, upper slices come from the snapshot when it owns this register.
    always_comb begin
        rd_word_c = live_pad_c[31:0];
        for (int unsigned k = 1; k < WPR; k++) begin
            if (acc_slice_q == SLW'(k))
                rd_word_c = use_snap_c ? snap_pad_c[k*32 +: 32] : live_pad_c[k*32 +: 32];
        end
    end

    // Commit value: staged lower slices with the final-slice data on top.
    always_comb begin
        wcomp_c = wsh_q;
        wcomp_c[PADW-1 -: 32] = wdata_q;
    end

    // Access FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_reg_q   <= 1'b0;
            acc_mem_q   <= 1'b0;
            acc_wr_q    <= 1'b0;
            acc_idx_q   <= '0;
            acc_slice_q <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            wsh_q       <= '0;
            wown_q      <= '0;
            rsh_q       <= '0;
            rown_q      <= '0;
            rvalid_q    <= 1'b0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            ext_write_q <= '0;
            ext_wdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            ext_write_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    if (psel && !penable) begin
                        acc_reg_q   <= dec_reg_c;
                        acc_mem_q   <= dec_mem_c;
                        acc_wr_q    <= pwrite;
                        acc_idx_q   <= dec_idx_c;
                        acc_slice_q <= dec_slice_c;
                        wdata_q     <= pwdata;
                        if (dec_mem_c) begin
                            mem_en_q   <= 1'b1;
                            mem_we_q   <= pwrite;
                            mem_addr_q <= word_c[MEM_AW-1:0];
                            if (pwrite) mem_wdata_q <= pwdata[MEM_DW-1:0];
                        end
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (acc_mem_q) begin
                        if (acc_wr_q) begin
                            pready_q <= 1'b1;
                            state_q  <= RESP;
                        end else begin
                            cnt_q   <= CNTW'(MEM_RD_LAT - 1);
                            state_q <= MEM_WAIT;
                        end
                    end else if (acc_reg_q) begin
                        if (acc_wr_q) begin
                            if (acc_slice_q == SLW'(WPR - 1)) begin
                                ext_wdata_q <= wcomp_c[DATA_W-1:0];
                                ext_write_q <= NUM_EXT'(1) << acc_idx_q;
                                wsh_q       <= '0;
                            end else begin
                                // A new register starting at slice 0 drops someone else's partial data.
                                if (acc_slice_q == '0 && acc_idx_q != wown_q) begin
                                    wsh_q <= PADW'(wdata_q);
                                end else begin
                                    for (int unsigned k = 0; k < WPR - 1; k++) begin
                                        if (acc_slice_q == SLW'(k)) wsh_q[k*32 +: 32] <= wdata_q;
                                    end
                                end
                                wown_q <= acc_idx_q;
                            end
                        end else begin
                            prdata_q <= rd_word_c;
                            if (acc_slice_q == '0) begin
                                rsh_q    <= live_c;
                                rown_q   <= acc_idx_q;
                                rvalid_q <= 1'b1;
                            end
                        end
                        pready_q <= 1'b1;
                        state_q  <= RESP;
                    end else begin
                        prdata_q  <= '0;
                        pslverr_q <= 1'b1;
                        pready_q  <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                MEM_WAIT: begin
                    // Wait spans MEM_RD_LAT cycles so data launched that long after mem_en is captured.
                    if (cnt_q == '0) begin
                        prdata_q <= 32'(mem_rdata);
                        pready_q <= 1'b1;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
                RESP: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prdata    = prdata_q;
    assign pready    = pready_q;
    assign pslverr   = pslverr_q;
    assign ext_write = ext_write_q;
    assign ext_wdata = ext_wdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_apb_wide_reg_bank.sv
// Scoreboard bench for apb_wide_reg_bank: driver queues expected responses, monitor checks them.
module tb_apb_wide_reg_bank;

    localparam int unsigned NUM_EXT    = 4;
    localparam int unsigned DATA_W     = 37;
    localparam int unsigned MEM_AW     = 6;
    localparam int unsigned MEM_DW     = 32;
    localparam int unsigned MEM_RD_LAT = 3;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned MEM_BASE   = 512;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [ADDR_W-1:0]         paddr = '0;
    logic [31:0]               pwdata = '0;
    logic [31:0]               prdata;
    logic                      pready, pslverr;
    logic [NUM_EXT-1:0]        ext_write;
    logic [DATA_W-1:0]         ext_wdata;
    logic [NUM_EXT*DATA_W-1:0] ext_rdata = '0;
    logic                      mem_en, mem_we;
    logic [MEM_AW-1:0]         mem_addr;
    logic [MEM_DW-1:0]         mem_wdata;
    logic [MEM_DW-1:0]         mem_rdata;

    apb_wide_reg_bank #(
        .NUM_EXT(NUM_EXT), .DATA_W(DATA_W), .MEM_AW(MEM_AW),
        .MEM_DW(MEM_DW), .MEM_RD_LAT(MEM_RD_LAT), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .ext_write(ext_write), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic err; bit chk; string name; } resp_t;
    typedef struct { logic [NUM_EXT-1:0] mask; logic [DATA_W-1:0] data; } ext_t;
    typedef struct { logic we; logic [MEM_AW-1:0] addr; logic [MEM_DW-1:0] data; } mem_t;

    resp_t resp_q[$];
    ext_t  ext_q[$];
    mem_t  mem_q[$];
    int    checks = 0;
    int    errors = 0;

    // Memory model: writes land immediately, read data appears MEM_RD_LAT cycles after the strobe.
    logic [MEM_DW-1:0] mem_arr [2**MEM_AW];
    logic [MEM_DW-1:0] pipe [MEM_RD_LAT];
    assign mem_rdata = pipe[MEM_RD_LAT-1];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem_arr[mem_addr] <= mem_wdata;
        pipe[0] <= (mem_en && !mem_we) ? mem_arr[mem_addr] : 32'hBAD0BAD0;
        for (int i = 1; i < MEM_RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_ext(input int unsigned i, input logic [DATA_W-1:0] v);
        ext_rdata[i*DATA_W +: DATA_W] = v;
    endtask

    // One APB transfer; expected response pushed before the bus is driven.
    task automatic apb(input bit wr, input int unsigned word, input logic [31:0] d,
                       input logic [31:0] exp_d, input bit chk, input bit exp_err,
                       input int unsigned exp_wait, input string name);
        int unsigned waits;
        bit done;
        resp_q.push_back('{exp_d, exp_err, chk, name});
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; pwdata = d;
        paddr = ADDR_W'((word << 2) | (word & 32'd3));
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0; done = 1'b0;
        while (!done && waits < 20) begin
            @(negedge clk);
            if (pready) done = 1'b1;
            else waits++;
        end
        check({name, "_wait"}, 64'(waits), 64'(exp_wait));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a response, commit or memory strobe.
    initial begin
        resp_t r;
        ext_t  e;
        mem_t  m;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pready) begin
                    if (resp_q.size() == 0) begin
                        check("unexpected_pready", 64'(pready), 64'(0));
                    end else begin
                        r = resp_q.pop_front();
                        if (r.chk) check({r.name, "_prdata"}, 64'(prdata), 64'(r.data));
                        check({r.name, "_pslverr"}, 64'(pslverr), 64'(r.err));
                    end
                end else if (pslverr) begin
                    check("pslverr_outside_resp", 64'(pslverr), 64'(0));
                end
                if (ext_write != '0) begin
                    if (ext_q.size() == 0) begin
                        check("unexpected_ext_write", 64'(ext_write), 64'(0));
                    end else begin
                        e = ext_q.pop_front();
                        check("ext_write_mask", 64'(ext_write), 64'(e.mask));
                        check("ext_wdata", 64'(ext_wdata), 64'(e.data));
                    end
                end
                if (mem_en) begin
                    if (mem_q.size() == 0) begin
                        check("unexpected_mem_en", 64'(mem_en), 64'(0));
                    end else begin
                        m = mem_q.pop_front();
                        check("mem_we", 64'(mem_we), 64'(m.we));
                        check("mem_addr", 64'(mem_addr), 64'(m.addr));
                        if (m.we) check("mem_wdata", 64'(mem_wdata), 64'(m.data));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < MEM_RD_LAT; i++) pipe[i] = '0;
        for (int i = 0; i < 2**MEM_AW; i++) mem_arr[i] = '0;
        set_ext(0, 37'h1063686172);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_prdata", 64'(prdata), 64'(0));
        check("rst_pready", 64'(pready), 64'(0));
        check("rst_pslverr", 64'(pslverr), 64'(0));
        check("rst_ext", 64'({ext_write, ext_wdata}), 64'(0));
        check("rst_mem", 64'({mem_en, mem_we, mem_addr}), 64'(0));
        @(posedge clk); #1 rst = 1'b0;

        // First read, snapshot upper slice
        apb(0, 0, 0, 32'h63686172, 1, 0, 1, "rd_reg0_s0");
        apb(0, 1, 0, 32'h00000010, 1, 0, 1, "rd_reg0_s1");

        // Atomic write: slice 0 staged, slice 1 commits
        apb(1, 2, 32'hDEADBEEF, 0, 0, 0, 1, "wr_reg1_s0");
        ext_q.push_back('{4'b0010, 37'h1FDEADBEEF});
        apb(1, 3, 32'h0000001F, 0, 0, 0, 1, "wr_reg1_s1");

        // Truncation of the final slice
        apb(1, 0, 32'h12345678, 0, 0, 0, 1, "wr_reg0_s0");
        ext_q.push_back('{4'b0001, 37'h0312345678});
        apb(1, 1, 32'hFFFFFFE3, 0, 0, 0, 1, "wr_reg0_s1");

        // Coherent read through the snapshot
        set_ext(2, 37'h0A12345678);
        apb(0, 4, 0, 32'h12345678, 1, 0, 1, "rd_reg2_s0");
        set_ext(2, 37'h1587654321);
        apb(0, 5, 0, 32'h0000000A, 1, 0, 1, "rd_reg2_s1_snap");
        apb(0, 4, 0, 32'h87654321, 1, 0, 1, "rd_reg2_s0_b");
        apb(0, 5, 0, 32'h00000015, 1, 0, 1, "rd_reg2_s1_b");
        set_ext(3, 37'h0C00000000);
        apb(0, 7, 0, 32'h0000000C, 1, 0, 1, "rd_reg3_s1_live");
        set_ext(2, 37'h0300000000);
        apb(0, 5, 0, 32'h00000015, 1, 0, 1, "rd_reg2_s1_kept");

        // Shared write shadow taken over by another register
        apb(1, 0, 32'hAAAAAAAA, 0, 0, 0, 1, "wr_reg0_partial");
        apb(1, 6, 32'h00000055, 0, 0, 0, 1, "wr_reg3_s0");
        ext_q.push_back('{4'b1000, 37'h0100000055});
        apb(1, 7, 32'h00000001, 0, 0, 0, 1, "wr_reg3_s1");

        // Memory window, including its last word
        mem_q.push_back('{1'b1, 6'd5, 32'h000000A5});
        apb(1, MEM_BASE + 5, 32'h000000A5, 0, 0, 0, 1, "mem_wr5");
        mem_q.push_back('{1'b0, 6'd5, 32'h0});
        apb(0, MEM_BASE + 5, 0, 32'h000000A5, 1, 0, 1 + MEM_RD_LAT, "mem_rd5");
        mem_q.push_back('{1'b1, 6'd63, 32'hCAFEF00D});
        apb(1, MEM_BASE + 63, 32'hCAFEF00D, 0, 0, 0, 1, "mem_wr63");
        mem_q.push_back('{1'b0, 6'd63, 32'h0});
        apb(0, MEM_BASE + 63, 0, 32'hCAFEF00D, 1, 0, 1 + MEM_RD_LAT, "mem_rd63");

        // Unmapped words
        apb(0, NUM_EXT * 2, 0, 32'h0, 1, 1, 1, "unmap_rd8");
        apb(1, MEM_BASE + 64, 32'h11111111, 32'h0, 1, 1, 1, "unmap_wr576");
        apb(0, 1023, 0, 32'h0, 1, 1, 1, "unmap_rd1023");

        // Reset after a partial write drops the staged slice
        apb(1, 2, 32'h0000000B, 0, 0, 0, 1, "wr_reg1_partial");
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ext_q.push_back('{4'b0010, 37'h0200000000});
        apb(1, 3, 32'h22222222, 0, 0, 0, 1, "wr_reg1_after_rst");

        // Reset during MEM_WAIT abandons the read
        mem_q.push_back('{1'b0, 6'd5, 32'h0});
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
        paddr = ADDR_W'((MEM_BASE + 5) << 2);
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("memwait_rst_prdata", 64'(prdata), 64'(0));
        check("memwait_rst_pready", 64'(pready), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) @(posedge clk);

        // Clean access afterwards; the read snapshot was cleared so slice 1 is live
        apb(0, 5, 0, 32'h00000003, 1, 0, 1, "rd_reg2_s1_post_rst");
        apb(0, 0, 0, 32'h63686172, 1, 0, 1, "rd_reg0_post_rst");

        repeat (6) @(posedge clk);
        check("resp_q_empty", 64'(resp_q.size()), 64'(0));
        check("ext_q_empty", 64'(ext_q.size()), 64'(0));
        check("mem_q_empty", 64'(mem_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
